// File: rtl/dpram_req_sched.sv
// dpram_req_sched: per-channel request FIFOs and registered issue stages driving a 64x8 write-first dual-port RAM.
// Optional macro DPRAM_SCHED_COLLISION_EN: serialise same-address cross-port hazards and count them.
module dpram_req_sched #(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = 6,
  localparam int unsigned DW    = 8,
  localparam int unsigned CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_wdata,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic            b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_wdata,
  output logic [AW-1:0]   ram_addr_a,
  output logic [DW-1:0]   ram_data_a,
  output logic            ram_we_a,
  output logic [AW-1:0]   ram_addr_b,
  output logic [DW-1:0]   ram_data_b,
  output logic            ram_we_b,
  output logic            a_rsp_valid,
  output logic            b_rsp_valid,
  output logic [CNTW-1:0] collision_cnt
);

  localparam int unsigned NCH = 2;
  localparam int unsigned PW  = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CW  = PW + 1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t           mem_q    [NCH][DEPTH];
  req_t           in_req   [NCH];
  req_t           head     [NCH];
  logic [PW-1:0]  wr_ptr_q [NCH];
  logic [PW-1:0]  wr_ptr_d [NCH];
  logic [PW-1:0]  rd_ptr_q [NCH];
  logic [PW-1:0]  rd_ptr_d [NCH];
  logic [CW-1:0]  cnt_q    [NCH];
  logic [CW-1:0]  cnt_d    [NCH];
  logic [AW-1:0]  addr_q   [NCH];
  logic [AW-1:0]  addr_d   [NCH];
  logic [DW-1:0]  data_q   [NCH];
  logic [DW-1:0]  data_d   [NCH];
  logic [NCH-1:0] ready_q, ready_d;
  logic [NCH-1:0] we_q, we_d;
  logic [NCH-1:0] iss_q, iss_d;
  logic [NCH-1:0] rsp_q, rsp_d;
  logic [NCH-1:0] push, pop, nonempty;

  // Channel index 0 is A, 1 is B.
  always_comb begin
    in_req[0] = '{we: a_we, addr: a_addr, wdata: a_wdata};
    in_req[1] = '{we: b_we, addr: b_addr, wdata: b_wdata};
    push      = {b_valid & ready_q[1], a_valid & ready_q[0]};
    for (int c = 0; c < NCH; c++) begin
      nonempty[c] = (cnt_q[c] != '0);
      head[c]     = mem_q[c][rd_ptr_q[c]];
    end
  end

`ifdef DPRAM_SCHED_COLLISION_EN
  logic            hazard;
  logic            prio_b_q, prio_b_d;
  logic [CNTW-1:0] coll_q, coll_d;

  // On a hazard only the priority port pops; priority alternates after every hazard.
  always_comb begin
    hazard   = nonempty[0] & nonempty[1] & (head[0].addr == head[1].addr)
             & (head[0].we | head[1].we);
    pop[0]   = nonempty[0] & ~(hazard & prio_b_q);
    pop[1]   = nonempty[1] & ~(hazard & ~prio_b_q);
    prio_b_d = prio_b_q;
    coll_d   = coll_q;
    if (hazard) begin
      prio_b_d = ~prio_b_q;
      if (coll_q != {CNTW{1'b1}}) coll_d = coll_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_b_q <= 1'b0;
      coll_q   <= '0;
    end else begin
      prio_b_q <= prio_b_d;
      coll_q   <= coll_d;
    end
  end

  assign collision_cnt = coll_q;
`else
  always_comb pop = nonempty;

  assign collision_cnt = '0;
`endif

  // FIFO bookkeeping and issue-stage next state.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      addr_d[c]   = addr_q[c];
      data_d[c]   = data_q[c];
      if (push[c]) begin
        wr_ptr_d[c] = (wr_ptr_q[c] == PW'(DEPTH - 1)) ? '0 : wr_ptr_q[c] + PW'(1);
      end
      if (pop[c]) begin
        rd_ptr_d[c] = (rd_ptr_q[c] == PW'(DEPTH - 1)) ? '0 : rd_ptr_q[c] + PW'(1);
        addr_d[c]   = head[c].addr;
        data_d[c]   = head[c].wdata;
      end
      cnt_d[c]   = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
      ready_d[c] = (cnt_d[c] != CW'(DEPTH));
      we_d[c]    = pop[c] & head[c].we;
      iss_d[c]   = pop[c];
      rsp_d[c]   = iss_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= '0;
      we_q    <= '0;
      iss_q   <= '0;
      rsp_q   <= '0;
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
        addr_q[c]   <= '0;
        data_q[c]   <= '0;
      end
    end else begin
      ready_q <= ready_d;
      we_q    <= we_d;
      iss_q   <= iss_d;
      rsp_q   <= rsp_d;
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
        addr_q[c]   <= addr_d[c];
        data_q[c]   <= data_d[c];
      end
    end
  end

  // Entry storage needs no reset: pointers and occupancy define which entries are live.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst_n && push[c]) mem_q[c][wr_ptr_q[c]] <= in_req[c];
    end
  end

  assign a_ready     = ready_q[0];
  assign b_ready     = ready_q[1];
  assign ram_addr_a  = addr_q[0];
  assign ram_data_a  = data_q[0];
  assign ram_we_a    = we_q[0];
  assign ram_addr_b  = addr_q[1];
  assign ram_data_b  = data_q[1];
  assign ram_we_b    = we_q[1];
  assign a_rsp_valid = rsp_q[0];
  assign b_rsp_valid = rsp_q[1];

endmodule

// File: tb/tb_dpram_req_sched.sv
// tb_dpram_req_sched: directed and random traffic against a queue-based reference model and a behavioural RAM.
// Hazard scenarios are exercised when DPRAM_SCHED_COLLISION_EN is defined.
module tb_dpram_req_sched;

  localparam int DEPTH = 2;

`ifdef DPRAM_SCHED_COLLISION_EN
  localparam logic [5:0] HZ_A = 6'd9;
  localparam logic [5:0] HZ_B = 6'd9;
  localparam int A_LO = 0, A_HI = 7, B_LO = 0, B_HI = 7;
`else
  localparam logic [5:0] HZ_A = 6'd9;
  localparam logic [5:0] HZ_B = 6'd41;
  localparam int A_LO = 0, A_HI = 31, B_LO = 32, B_HI = 63;
`endif

  typedef struct packed {
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
  } req_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_we, b_valid, b_we;
  logic [5:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ready, b_ready;
  logic [5:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_data_a, ram_data_b;
  logic       ram_we_a, ram_we_b;
  logic       a_rsp_valid, b_rsp_valid;
  logic [7:0] collision_cnt;

  dpram_req_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a),
    .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_we_b(ram_we_b),
    .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid), .collision_cnt(collision_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural 64x8 write-first dual-port RAM driven by the DUT.
  logic [7:0] ram [64];
  logic [7:0] q_a, q_b;
  logic       ram_clr = 1'b1;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= 8'h00;
      ram_clr <= 1'b0;
    end else begin
      q_a <= ram_we_a ? ram_data_a : ram[ram_addr_a];
      q_b <= ram_we_b ? ram_data_b : ram[ram_addr_b];
      if (ram_we_a) ram[ram_addr_a] <= ram_data_a;
      if (ram_we_b) ram[ram_addr_b] <= ram_data_b;
    end
  end

  // Reference model state.
  req_t       qa[$], qb[$];
  logic       m_iss_a = 1'b0, m_iss_b = 1'b0;
  req_t       m_ir_a = '0, m_ir_b = '0;
  logic       m_rsp_a = 1'b0, m_rsp_b = 1'b0;
  logic [7:0] m_q_a, m_q_b;
  logic [7:0] mmem [64];
  logic       m_rdy_a = 1'b0, m_rdy_b = 1'b0;
  logic       m_prio_b = 1'b0;
  int         m_coll = 0;
  int         m_acc_a = 0, m_acc_b = 0;

  int         n_checks = 0, n_fail = 0;
  int         n_rsp_a = 0, n_rsp_b = 0;
  logic [7:0] last_q_a, last_q_b;
  logic       saw_a_busy = 1'b0;

  localparam req_t NOP = '0;

  function automatic req_t mk(input logic we, input logic [5:0] addr, input logic [7:0] d);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = d;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge of the reference: RAM samples issue regs, then heads issue, then pushes land.
  task automatic model_edge(input logic av, input req_t ar, input logic bv, input req_t br);
    logic ha, hb, haz, ia, ib;
    if (m_iss_a && m_ir_a.we) mmem[m_ir_a.addr] = m_ir_a.wdata;
    if (m_iss_b && m_ir_b.we) mmem[m_ir_b.addr] = m_ir_b.wdata;
    m_q_a = mmem[m_ir_a.addr];
    m_q_b = mmem[m_ir_b.addr];
    if (!rst_n) begin
      qa.delete(); qb.delete();
      m_iss_a = 1'b0; m_iss_b = 1'b0; m_ir_a = '0; m_ir_b = '0;
      m_rsp_a = 1'b0; m_rsp_b = 1'b0; m_prio_b = 1'b0; m_coll = 0;
      m_rdy_a = 1'b0; m_rdy_b = 1'b0;
      return;
    end
    m_rsp_a = m_iss_a;
    m_rsp_b = m_iss_b;
    ha  = (qa.size() != 0);
    hb  = (qb.size() != 0);
    haz = 1'b0;
`ifdef DPRAM_SCHED_COLLISION_EN
    if (ha && hb) haz = (qa[0].addr == qb[0].addr) && (qa[0].we || qb[0].we);
`endif
    ia = ha && !(haz && m_prio_b);
    ib = hb && !(haz && !m_prio_b);
    if (haz) begin
      m_prio_b = m_prio_b ? 1'b0 : 1'b1;
      if (m_coll < 255) m_coll++;
    end
    m_iss_a = ia;
    m_iss_b = ib;
    if (ia) m_ir_a = qa.pop_front();
    if (ib) m_ir_b = qb.pop_front();
    if (av && m_rdy_a) begin qa.push_back(ar); m_acc_a++; end
    if (bv && m_rdy_b) begin qb.push_back(br); m_acc_b++; end
    m_rdy_a = (qa.size() < DEPTH);
    m_rdy_b = (qb.size() < DEPTH);
  endtask

  task automatic check_outputs();
    chk("a_ready", 32'(a_ready), 32'(m_rdy_a));
    chk("b_ready", 32'(b_ready), 32'(m_rdy_b));
    chk("ram_we_a", 32'(ram_we_a), 32'(m_iss_a && m_ir_a.we));
    chk("ram_we_b", 32'(ram_we_b), 32'(m_iss_b && m_ir_b.we));
    chk("ram_addr_a", 32'(ram_addr_a), 32'(m_ir_a.addr));
    chk("ram_addr_b", 32'(ram_addr_b), 32'(m_ir_b.addr));
    if (m_iss_a && m_ir_a.we) chk("ram_data_a", 32'(ram_data_a), 32'(m_ir_a.wdata));
    if (m_iss_b && m_ir_b.we) chk("ram_data_b", 32'(ram_data_b), 32'(m_ir_b.wdata));
    chk("a_rsp_valid", 32'(a_rsp_valid), 32'(m_rsp_a));
    chk("b_rsp_valid", 32'(b_rsp_valid), 32'(m_rsp_b));
    if (m_rsp_a) chk("q_a", 32'(q_a), 32'(m_q_a));
    if (m_rsp_b) chk("q_b", 32'(q_b), 32'(m_q_b));
    chk("collision_cnt", 32'(collision_cnt), 32'(m_coll));
    if (a_rsp_valid === 1'b1) begin n_rsp_a++; last_q_a = q_a; end
    if (b_rsp_valid === 1'b1) begin n_rsp_b++; last_q_b = q_b; end
  endtask

  task automatic step(input logic av, input req_t ar, input logic bv, input req_t br);
    a_valid = av; a_we = ar.we; a_addr = ar.addr; a_wdata = ar.wdata;
    b_valid = bv; b_we = br.we; b_addr = br.addr; b_wdata = br.wdata;
    @(posedge clk);
    model_edge(av, ar, bv, br);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, NOP, 1'b0, NOP);
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_a_ready"}, 32'(a_ready), 32'd0);
    chk({tag, "_b_ready"}, 32'(b_ready), 32'd0);
    chk({tag, "_ram_we_a"}, 32'(ram_we_a), 32'd0);
    chk({tag, "_ram_we_b"}, 32'(ram_we_b), 32'd0);
    chk({tag, "_ram_addr_a"}, 32'(ram_addr_a), 32'd0);
    chk({tag, "_ram_addr_b"}, 32'(ram_addr_b), 32'd0);
    chk({tag, "_ram_data_a"}, 32'(ram_data_a), 32'd0);
    chk({tag, "_ram_data_b"}, 32'(ram_data_b), 32'd0);
    chk({tag, "_a_rsp"}, 32'(a_rsp_valid), 32'd0);
    chk({tag, "_b_rsp"}, 32'(b_rsp_valid), 32'd0);
    chk({tag, "_coll"}, 32'(collision_cnt), 32'd0);
  endtask

  // Both channels stream writes with valid held; a request stays on the bus until accepted.
  task automatic stream(input int n, input logic [5:0] aa, input logic [5:0] ba);
    req_t ra, rb;
    logic acc_a, acc_b;
    ra = mk(1'b1, aa, 8'($urandom));
    rb = mk(1'b1, ba, 8'($urandom));
    for (int i = 0; i < n; i++) begin
      acc_a = m_rdy_a;
      acc_b = m_rdy_b;
      step(1'b1, ra, 1'b1, rb);
      if (a_ready === 1'b0) saw_a_busy = 1'b1;
      if (acc_a) ra = mk(1'b1, aa, 8'($urandom));
      if (acc_b) rb = mk(1'b1, ba, 8'($urandom));
    end
  endtask

  task automatic random_traffic(input int n);
    logic av, bv, acc_a, acc_b;
    req_t ra, rb;
    av = 1'b0; bv = 1'b0; ra = NOP; rb = NOP;
    acc_a = 1'b1; acc_b = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (acc_a || !av) begin
        av = 1'($urandom_range(0, 1));
        ra = mk(1'($urandom_range(0, 1)), 6'($urandom_range(A_HI, A_LO)), 8'($urandom));
      end
      if (acc_b || !bv) begin
        bv = 1'($urandom_range(0, 1));
        rb = mk(1'($urandom_range(0, 1)), 6'($urandom_range(B_HI, B_LO)), 8'($urandom));
      end
      acc_a = av && m_rdy_a;
      acc_b = bv && m_rdy_b;
      step(av, ra, bv, rb);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 64; i++) mmem[i] = 8'h00;

    idle(3);
    check_reset_zero("reset");
    rst_n = 1'b1;
    idle(1);
    chk("post_reset_a_ready", 32'(a_ready), 32'd1);
    chk("post_reset_b_ready", 32'(b_ready), 32'd1);

    // A writes 0x3C to address 5, then reads it back.
    step(1'b1, mk(1'b1, 6'd5, 8'h3C), 1'b0, NOP);
    idle(1);
    chk("wr5_rsp_early", 32'(a_rsp_valid), 32'd0);
    idle(1);
    chk("wr5_rsp", 32'(a_rsp_valid), 32'd1);
    chk("wr5_q", 32'(q_a), 32'h3C);
    step(1'b1, mk(1'b0, 6'd5, 8'h00), 1'b0, NOP);
    idle(2);
    chk("rd5_rsp", 32'(a_rsp_valid), 32'd1);
    chk("rd5_q", 32'(last_q_a), 32'h3C);
    idle(2);

`ifdef DPRAM_SCHED_COLLISION_EN
    // Same-cycle write/write to address 9: A first, B one cycle later.
    step(1'b1, mk(1'b1, 6'd9, 8'h11), 1'b1, mk(1'b1, 6'd9, 8'h22));
    idle(1);
    chk("ww9_a_first", 32'(ram_we_a), 32'd1);
    chk("ww9_b_held", 32'(ram_we_b), 32'd0);
    chk("ww9_coll", 32'(collision_cnt), 32'd1);
    idle(1);
    chk("ww9_b_second", 32'(ram_we_b), 32'd1);
    chk("ww9_a_done", 32'(ram_we_a), 32'd0);
    idle(2);
    step(1'b1, mk(1'b0, 6'd9, 8'h00), 1'b0, NOP);
    idle(2);
    chk("ww9_read", 32'(last_q_a), 32'h22);
    // Second hazard: B now holds priority.
    step(1'b1, mk(1'b1, 6'd9, 8'h33), 1'b1, mk(1'b1, 6'd9, 8'h44));
    idle(1);
    chk("hz2_b_first", 32'(ram_we_b), 32'd1);
    chk("hz2_a_held", 32'(ram_we_a), 32'd0);
    chk("hz2_coll", 32'(collision_cnt), 32'd2);
    idle(1);
    chk("hz2_a_second", 32'(ram_we_a), 32'd1);
    idle(3);
`endif

    // Backpressure: continuous streams; every accepted request yields exactly one response.
    n_rsp_a = 0; n_rsp_b = 0; m_acc_a = 0; m_acc_b = 0; saw_a_busy = 1'b0;
    stream(24, HZ_A, HZ_B);
    idle(10);
    chk("bp_rsp_count_a", 32'(n_rsp_a), 32'(m_acc_a));
    chk("bp_rsp_count_b", 32'(n_rsp_b), 32'(m_acc_b));
`ifdef DPRAM_SCHED_COLLISION_EN
    chk("bp_a_ready_dropped", 32'(saw_a_busy), 32'd1);

    // Drive well over 255 hazards; the counter must stick at 255.
    stream(350, HZ_A, HZ_B);
    idle(10);
    chk("coll_saturated", 32'(collision_cnt), 32'd255);
    stream(5, HZ_A, HZ_B);
    chk("coll_holds", 32'(collision_cnt), 32'd255);
    idle(10);
`endif

    // Reset with requests queued and in flight: nothing responds afterwards.
    stream(6, HZ_A, HZ_B);
    rst_n = 1'b0;
    idle(1);
    check_reset_zero("midrst");
    rst_n = 1'b1;
    idle(1);
    chk("midrst_a_ready", 32'(a_ready), 32'd1);
    chk("midrst_b_ready", 32'(b_ready), 32'd1);
    n_rsp_a = 0; n_rsp_b = 0;
    idle(5);
    chk("midrst_no_rsp_a", 32'(n_rsp_a), 32'd0);
    chk("midrst_no_rsp_b", 32'(n_rsp_b), 32'd0);

    random_traffic(600);
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_req_sched.md
# dpram_req_sched

Request scheduler that sits directly upstream of the 64×8 true dual-port write-first RAM. It accepts two independent valid/ready request streams (channel A, channel B) and buffers each in a 2-entry FIFO. It drives the RAM's per-port address, data and write-enable from registered issue stages. It detects same-address cross-port hazards and serialises them, and it flags the cycle in which each port's RAM output (q_a/q_b) holds that request's result.

## Interface
- `DEPTH`, 2: per-channel request FIFO depth. Legal values are 2 and 4.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `a_valid` in 1: channel A request present.
- `a_ready` out 1: channel A FIFO can accept a request.
- `a_we` in 1: 1 = write, 0 = read.
- `a_addr` in 6: word address.
- `a_wdata` in 8: write data; ignored for reads.
- `b_valid`, `b_ready`, `b_we`, `b_addr`, `b_wdata`: same as channel A, for channel B.
- `ram_addr_a` out 6, `ram_data_a` out 8, `ram_we_a` out 1: RAM port A drive.
- `ram_addr_b` out 6, `ram_data_b` out 8, `ram_we_b` out 1: RAM port B drive.
- `a_rsp_valid` out 1: RAM `q_a` holds the result of a channel A request this cycle.
- `b_rsp_valid` out 1: same for RAM `q_b` and channel B.
- `collision_cnt` out 8: saturating count of detected hazards.

## Operation
- **Accept.** A request is accepted on a rising edge where `x_valid && x_ready`, and is pushed into that channel's FIFO.
  - `x_ready` = FIFO not full, computed from registered occupancy.
  - A push into a full FIFO cannot occur.
- **Issue.** On each edge, each non-empty FIFO whose head is not stalled pops its head into that port's issue register.
  - The issue register drives `ram_addr_x`, `ram_data_x` and `ram_we_x`.
  - `ram_we_x` is high for exactly one cycle per issued write.
  - An empty or stalled port loads `ram_we_x = 0`. Address and data hold their last values.
- **Issue tracking.** An `iss_x` flag records that port x issued a request, read or write.
- **Response.** `x_rsp_valid` is `iss_x` delayed by one cycle.
  - For writes, the RAM is write-first, so `q_x` equals the written data.
- **Hazard.** A hazard exists when both heads are eligible, `a_addr == b_addr`, and at least one of the two is a write.
- **Hazard resolution** (macro enabled):
  - Only the priority port issues; the other port holds its head and issues on the next edge.
  - Default priority is A.
  - A `prio_b` bit sets after B loses a hazard, so B wins the next hazard. It clears after B wins.
  - `collision_cnt` increments by 1 per hazard and saturates at 255.
- **Simultaneous push/pop** on the same FIFO in one cycle is legal. Occupancy is unchanged.
- **FIFO pointers** wrap modulo `DEPTH`.
- **Reset** (`rst_n` low at an edge):
  - Both FIFOs are emptied.
  - `ready` = 0, `ram_we_x` = 0, `ram_addr_x` = 0, `ram_data_x` = 0.
  - `rsp_valid` = 0, `prio_b` = 0, `collision_cnt` = 0.
  - Reset asserted mid-stream discards all queued and in-flight requests. No `rsp_valid` is produced for them.
  - `x_ready` goes high in the first cycle after the edge that samples `rst_n` = 1.

## Timing
- Accept at edge N → issue register loaded at N+1 (if the FIFO was empty and there is no stall).
- RAM samples the issue register at N+2.
- `x_rsp_valid` is high in the cycle after N+2, concurrent with valid `q_x`.
- Accept-to-response latency is 2 cycles minimum, plus 1 cycle per hazard stall.
- Sustained throughput per channel is 1 request/cycle with no hazards.
- Requests are issued strictly in acceptance order within a channel. No ordering is guaranteed across channels except as set by hazard priority.

## Configuration
- `DPRAM_SCHED_COLLISION_EN` defined:
  - The address comparator, stall logic, `prio_b` and `collision_cnt` are compiled in, as described above.
- Not defined:
  - There is no comparison; both heads always issue in the same cycle.
  - `collision_cnt` is tied to 0.
  - Same-address write/write behaviour is whatever the RAM does.

## Test plan
- **A write then A read, address 5.** A writes 0x3C to addr 5, then A reads addr 5 → `a_rsp_valid` 2 cycles after each accept. `q_a` = 0x3C for both.
- **Same-cycle write/write, address 9, macro on.** A writes 0x11 and B writes 0x22 to addr 9 in the same cycle → A issues first, B one cycle later. `collision_cnt` = 1. A subsequent read of addr 9 returns 0x22.
- **Two hazards back-to-back, macro on.** → Second hazard: B issues before A (`prio_b`). `collision_cnt` = 2.
- **Backpressure.** Hold the RAM side busy by continuous hazards and keep `a_valid` high → `a_ready` drops after `DEPTH` queued requests. No request is lost or duplicated; count the responses.
- **Reset mid-stream.** Reset with 2 queued requests and 1 issued → no `rsp_valid` afterwards. All outputs are 0. `ready` = 1 one cycle after `rst_n` rises.
- **Counter saturation.** Force 300 hazards → `collision_cnt` = 255 and holds.
